// File: rtl/cmos_pixel_packer.sv
// rtl/cmos_pixel_packer.sv - packs RATIO sensor samples per word with start-up frame skip and line/frame counters
module cmos_pixel_packer #(
   parameter int IN_W        = 8,
   parameter int RATIO       = 2,
   parameter int OUT_W       = IN_W * RATIO,
   parameter int SKIP_FRAMES = 2,
   parameter int CNT_W       = 12
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             vsync_i,
   input  logic             de_i,
   input  logic [IN_W-1:0]  pdata_i,
   input  logic             byte_swap,
   output logic [OUT_W-1:0] pdata_o,
   output logic             de_o,
   output logic             sof_o,
   output logic             href_o,
   output logic             err_partial,
   output logic [CNT_W-1:0] pix_cnt,
   output logic [CNT_W-1:0] line_cnt,
   output logic [15:0]      frame_cnt
);
   localparam int PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);
   localparam logic [3:0] SKIP_LAST = 4'(SKIP_FRAMES);

   typedef enum logic [1:0] {WAIT_VS, SKIP, RUN} state_t;

   state_t           state_q;
   logic             vsync_q, href_q;
   logic [PH_W-1:0]  ph_q, ph_d;
   logic [3:0]       skip_q;
   logic [IN_W-1:0]  acc_q [RATIO];
   logic [OUT_W-1:0] pdata_q, word_d;
   logic             de_q, sof_q, sof_pend_q, err_q;
   logic [CNT_W-1:0] pix_q, line_q;
   logic [15:0]      frame_q;
   logic [IN_W-1:0]  samp;

   logic run, vs_rise, act, done, de_fall;
   assign run     = (state_q == RUN);
   assign vs_rise = vsync_i & ~vsync_q;
   assign act     = de_i & ~vsync_i & run;
   assign done    = act & (ph_q == PH_LAST);
   assign de_fall = ~de_i & href_q;

   always_comb begin
      ph_d = ph_q;
      if (!de_i || vsync_i) ph_d = '0;
      else if (act)         ph_d = done ? '0 : ph_q + 1'b1;
   end

   // The last sample of a word bypasses the accumulator so the word registers on its own edge.
   always_comb begin
      word_d = '0;
      samp   = '0;
      for (int k = 0; k < RATIO; k++) begin
         samp = (k == RATIO - 1) ? pdata_i : acc_q[k];
         if (byte_swap) word_d[k*IN_W +: IN_W] = samp;
         else           word_d[(RATIO-1-k)*IN_W +: IN_W] = samp;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_VS;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         ph_q       <= '0;
         skip_q     <= '0;
         acc_q      <= '{default: '0};
         pdata_q    <= '0;
         de_q       <= 1'b0;
         sof_q      <= 1'b0;
         sof_pend_q <= 1'b0;
         err_q      <= 1'b0;
         pix_q      <= '0;
         line_q     <= '0;
         frame_q    <= '0;
      end else begin
         vsync_q <= vsync_i;
         href_q  <= de_i;
         ph_q    <= ph_d;
         if (act && !done) acc_q[ph_q] <= pdata_i;
         de_q    <= done;
         pdata_q <= done ? word_d : '0;
         sof_q   <= done & sof_pend_q;
         err_q   <= run & de_fall & (ph_q != '0);

         case (state_q)
            WAIT_VS: if (vs_rise) begin
               if (SKIP_FRAMES == 0) begin
                  state_q    <= RUN;
                  sof_pend_q <= 1'b1;
               end else begin
                  state_q <= SKIP;
               end
            end
            SKIP: if (vs_rise) begin
               skip_q <= skip_q + 4'd1;
               if (skip_q + 4'd1 == SKIP_LAST) begin
                  state_q    <= RUN;
                  sof_pend_q <= 1'b1;
               end
            end
            default: ;
         endcase

         if (run) begin
            if (vs_rise)   sof_pend_q <= 1'b1;
            else if (done) sof_pend_q <= 1'b0;
            if (done)         pix_q <= pix_q + 1'b1;
            else if (de_fall) pix_q <= '0;
            if (vs_rise)      line_q <= '0;
            else if (de_fall) line_q <= line_q + 1'b1;
            if (vs_rise) frame_q <= frame_q + 16'd1;
         end
      end
   end

   assign pdata_o     = pdata_q;
   assign de_o        = de_q;
   assign sof_o       = sof_q;
   assign href_o      = href_q;
   assign err_partial = err_q;
   assign pix_cnt     = pix_q;
   assign line_cnt    = line_q;
   assign frame_cnt   = frame_q;
endmodule

// File: doc/cmos_pixel_packer.md
# cmos_pixel_packer

Parametrised camera-side byte-to-word packer for the stereo capture path. It sits directly behind each CMOS sensor's parallel port and packs RATIO consecutive IN_W-bit samples into one OUT_W-bit pixel word, with selectable byte order. It also adds the frame-level control the downstream write DMA needs:
- discards a configurable number of start-up frames;
- drops and flags partial words at line end;
- produces start-of-frame, pixel, line and frame counters.

## Interface
Parameters:
- IN_W, 8, input sample width in bits.
- RATIO, 2, samples per output word; legal 1..4.
- OUT_W, IN_W*RATIO, output word width; derived, never overridden.
- SKIP_FRAMES, 2, frames discarded after reset, legal 0..15.
- CNT_W, 12, width of pixel and line counters.

Ports:
- pclk  in  1  sensor pixel clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- vsync_i  in  1  frame sync, active-high; its rising edge marks a frame boundary.
- de_i  in  1  line valid (HREF), active-high.
- pdata_i  in  IN_W  sensor sample, valid when de_i=1.
- byte_swap  in  1  0: first sample lands in MSBs; 1: first sample lands in LSBs. Quasi-static; change only while de_i=0.
- pdata_o  out  OUT_W  packed word; 0 whenever de_o=0.
- de_o  out  1  one-cycle strobe per packed word.
- sof_o  out  1  high together with the first de_o of every delivered frame.
- href_o  out  1  de_i registered by one cycle, independent of state.
- err_partial  out  1  one-cycle pulse when a line ends mid-word.
- pix_cnt  out  CNT_W  words emitted so far in the current line.
- line_cnt  out  CNT_W  completed lines in the current frame.
- frame_cnt  out  16  delivered frames since reset, wraps at 2^16.

## Operation
- Reset value of every output is 0. Reset sets state=WAIT_VS and clears the phase counter, skip counter and accumulator.
- Frame edge: vs_rise = vsync_i & ~vsync_q, where vsync_q is vsync_i registered once.
- States:
  - WAIT_VS: on vs_rise, go to SKIP, or to RUN if SKIP_FRAMES=0.
  - SKIP: each vs_rise increments skip_cnt; the vs_rise that makes skip_cnt==SKIP_FRAMES moves to RUN.
  - RUN: remains until reset.
- Qualified data: act = de_i & ~vsync_i & (state==RUN). de_i is ignored while vsync_i=1 or outside RUN.
- Phase counter ph (0..RATIO-1):
  - increments on act;
  - cleared when de_i=0 or vsync_i=1;
  - on act with ph==RATIO-1, a word completes and ph returns to 0.
- Accumulator holds the first RATIO-1 samples.
- Word assembly when the word completes:
  - byte_swap=0: {s0, s1, ..., s(R-1)}, with s0 the earliest sample.
  - byte_swap=1: {s(R-1), ..., s0}.
- Partial line: when de_i falls (de_i=0 while href_o=1) in RUN with ph!=0, the partial word is discarded and err_partial pulses for one cycle.
- Counters, in RUN only:
  - pix_cnt increments on each de_o and clears on de_i falling edge. After the last word of a line it is held for exactly one cycle, then cleared.
  - line_cnt increments on de_i falling edge and clears on vs_rise.
  - frame_cnt increments on vs_rise while in RUN, not on the vs_rise that enters RUN.
  - pix_cnt and line_cnt wrap modulo 2^CNT_W.
- sof_o: a flag is set on entering RUN and on every vs_rise in RUN. The flag qualifies the next de_o as sof_o and is cleared by it.
- RATIO=1: every act produces a word; err_partial never fires.

## Timing
- Latency: pdata_o, de_o and sof_o register at the same pclk edge that samples the final sample of the word. They are visible one cycle after that sample is presented.
- Throughput: one word per RATIO cycles of continuous de_i; de_o is never high on consecutive cycles unless RATIO=1.
- A de_i gap of one cycle mid-line is a line end: ph clears and the partial word is flagged.
- If vs_rise and de_i are high in the same cycle, vsync wins: no sample is taken and ph clears.
- Asynchronous reset mid-word: the word is lost and outputs go to 0 immediately. After release, the block waits for a fresh vs_rise and the full skip sequence.

## Test plan
- RATIO=2, SKIP_FRAMES=0, byte_swap=0: vsync pulse, then de_i for 4 cycles with 0x12, 0x34, 0x56, 0x78 → de_o two times, pdata_o=0x1234 then 0x5678; sof_o with 0x1234; pix_cnt 1, 2.
- Same stimulus with byte_swap=1 → 0x3412, 0x7856.
- SKIP_FRAMES=2: three frames of 2 lines × 4 bytes → no de_o in frames 0 and 1. Frame 2 yields 4 words, line_cnt reaches 2, frame_cnt=0; the next vs_rise gives frame_cnt=1 and line_cnt=0.
- RATIO=2, line of 5 bytes 0xA0..0xA4 → words 0xA0A1 and 0xA2A3, then err_partial one pulse the cycle after de_i falls; no third de_o.
- RATIO=3, IN_W=8, 6 bytes 0x01..0x06 → 0x010203 and 0x040506 with de_o 3 cycles apart; RATIO=1 → de_o every cycle, pdata_o=pdata_i one cycle later.
- Assert rst after 1 byte of a word in RUN → all outputs 0 at once. Post-release, de_i without vsync gives no de_o until vs_rise and completion of the skip sequence.
